// File: rtl/mcu_scheduler.sv
// Arbitrates the local-memory MCU between host line load/readback and compute-unit chunk
// writes, driving the MCU strobes and enforcing the line length with a byte counter.
module mcu_scheduler #(
    parameter int unsigned NUM_BITS = 512,
    parameter int unsigned BYTES    = NUM_BITS / 8,
    parameter int unsigned CW       = $clog2(BYTES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          host_load_req,
    input  logic          host_rd_req,
    input  logic          cu_wr_req,
    input  logic          host_in_valid,
    output logic          host_in_ready,
    input  logic          host_out_ready,
    output logic          host_out_valid,
    output logic          host_grant,
    output logic          cu_grant,
    output logic          mcu_line_read_from_host_en,
    output logic          mcu_line_write_to_host_en,
    output logic          mcu_chunk_read_from_bram_en,
    input  logic          mcu_done_flag,
    output logic [CW-1:0] byte_cnt,
    output logic          op_done,
    output logic          proto_err
);

    localparam logic [CW-1:0] LastByte = CW'(BYTES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCuWr,
        StHLoad,
        StHRead,
        StFinish
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic          last_host_q, last_host_d;
    logic          proto_err_q, proto_err_d;
    // Remember which operation is finishing so FINISH can update fairness and check completion.
    logic          op_load_q, op_load_d;
    logic          op_host_q, op_host_d;

    logic host_req;
    logic host_wins;

    assign host_req  = host_load_req | host_rd_req;
    // On a host/cu tie the side not served last wins.
    assign host_wins = host_req & (~cu_wr_req | ~last_host_q);

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        last_host_d = last_host_q;
        proto_err_d = proto_err_q;
        op_load_d   = op_load_q;
        op_host_d   = op_host_q;

        host_in_ready               = 1'b0;
        host_out_valid              = 1'b0;
        host_grant                  = 1'b0;
        cu_grant                    = 1'b0;
        mcu_line_read_from_host_en  = 1'b0;
        mcu_line_write_to_host_en   = 1'b0;
        mcu_chunk_read_from_bram_en = 1'b0;
        op_done                     = 1'b0;

        case (state_q)
            StIdle: begin
                byte_cnt_d = '0;
                if (host_wins) begin
                    op_host_d = 1'b1;
                    if (host_load_req) begin
                        state_d     = StHLoad;
                        op_load_d   = 1'b1;
                        proto_err_d = 1'b0;
                    end else begin
                        state_d   = StHRead;
                        op_load_d = 1'b0;
                    end
                end else if (cu_wr_req) begin
                    state_d   = StCuWr;
                    op_host_d = 1'b0;
                    op_load_d = 1'b0;
                end
            end

            StCuWr: begin
                cu_grant                    = 1'b1;
                mcu_chunk_read_from_bram_en = 1'b1;
                last_host_d                 = 1'b0;
                state_d                     = StFinish;
            end

            StHLoad: begin
                host_grant                 = 1'b1;
                host_in_ready              = 1'b1;
                mcu_line_read_from_host_en = host_in_valid;
                if (host_in_valid) begin
                    if (byte_cnt_q == LastByte) begin
                        byte_cnt_d = '0;
                        state_d    = StFinish;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CW'(1);
                    end
                end
            end

            StHRead: begin
                host_grant                = 1'b1;
                host_out_valid            = 1'b1;
                mcu_line_write_to_host_en = host_out_ready;
                if (host_out_ready) begin
                    if (byte_cnt_q == LastByte) begin
                        byte_cnt_d = '0;
                        state_d    = StFinish;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CW'(1);
                    end
                end
            end

            StFinish: begin
                op_done = 1'b1;
                if (op_host_q) begin
                    last_host_d = 1'b1;
                end
                // MCU must flag completion in the cycle after the last loaded byte.
                if (op_load_q && !mcu_done_flag) begin
                    proto_err_d = 1'b1;
                end
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            byte_cnt_q  <= '0;
            last_host_q <= 1'b0;
            proto_err_q <= 1'b0;
            op_load_q   <= 1'b0;
            op_host_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            last_host_q <= last_host_d;
            proto_err_q <= proto_err_d;
            op_load_q   <= op_load_d;
            op_host_q   <= op_host_d;
        end
    end

    assign byte_cnt  = byte_cnt_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mcu_scheduler.sv
// Scoreboarded bench for mcu_scheduler: expected operations are queued when requested and
// matched against what the monitor observes at each op_done.
`timescale 1ns/1ps
module tb_mcu_scheduler;

    localparam int unsigned NUM_BITS = 512;
    localparam int unsigned BYTES    = NUM_BITS / 8;
    localparam int unsigned CW       = $clog2(BYTES);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          host_load_req = 1'b0;
    logic          host_rd_req = 1'b0;
    logic          cu_wr_req = 1'b0;
    logic          host_in_valid = 1'b0;
    logic          host_in_ready;
    logic          host_out_ready = 1'b0;
    logic          host_out_valid;
    logic          host_grant;
    logic          cu_grant;
    logic          mcu_line_read_from_host_en;
    logic          mcu_line_write_to_host_en;
    logic          mcu_chunk_read_from_bram_en;
    logic          mcu_done_flag = 1'b0;
    logic [CW-1:0] byte_cnt;
    logic          op_done;
    logic          proto_err;

    mcu_scheduler #(
        .NUM_BITS(NUM_BITS)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .host_load_req              (host_load_req),
        .host_rd_req                (host_rd_req),
        .cu_wr_req                  (cu_wr_req),
        .host_in_valid              (host_in_valid),
        .host_in_ready              (host_in_ready),
        .host_out_ready             (host_out_ready),
        .host_out_valid             (host_out_valid),
        .host_grant                 (host_grant),
        .cu_grant                   (cu_grant),
        .mcu_line_read_from_host_en (mcu_line_read_from_host_en),
        .mcu_line_write_to_host_en  (mcu_line_write_to_host_en),
        .mcu_chunk_read_from_bram_en(mcu_chunk_read_from_bram_en),
        .mcu_done_flag              (mcu_done_flag),
        .byte_cnt                   (byte_cnt),
        .op_done                    (op_done),
        .proto_err                  (proto_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // kind: 0 = cu write, 1 = host load, 2 = host read
    typedef struct {
        int kind;
        int strobes;
    } exp_t;
    exp_t exp_q[$];

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int all_outs();
        return int'({host_in_ready, host_out_valid, host_grant, cu_grant,
                     mcu_line_read_from_host_en, mcu_line_write_to_host_en,
                     mcu_chunk_read_from_bram_en, op_done, proto_err, byte_cnt});
    endfunction

    // Monitor: tracks each granted operation and scores it at op_done.
    initial begin
        bit   in_op;
        int   mon_kind;
        int   mon_strb;
        int   strb;
        exp_t e;
        in_op    = 0;
        mon_kind = 0;
        mon_strb = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_op    = 0;
                mon_strb = 0;
            end else begin
                strb = int'(mcu_line_read_from_host_en) + int'(mcu_line_write_to_host_en) +
                       int'(mcu_chunk_read_from_bram_en);
                check_eq("strobe_exclusive", int'(strb <= 1), 1);
                if (!in_op && (cu_grant || host_grant)) begin
                    in_op    = 1;
                    mon_strb = 0;
                    mon_kind = cu_grant ? 0 : (host_in_ready ? 1 : 2);
                end
                mon_strb += strb;
                if (op_done) begin
                    check_eq("finish_no_grant", int'({host_grant, cu_grant}), 0);
                    check_eq("op_was_granted", int'(in_op), 1);
                    check_eq("op_done_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_eq("op_kind", mon_kind, e.kind);
                        check_eq("op_strobes", mon_strb, e.strobes);
                    end
                    in_op = 0;
                end
            end
        end
    end

    task automatic cu_op();
        exp_q.push_back('{0, 1});
        cu_wr_req = 1'b1;
        tick();
        cu_wr_req = 1'b0;
        check_eq("cu_grant", int'(cu_grant), 1);
        check_eq("cu_chunk_en", int'(mcu_chunk_read_from_bram_en), 1);
        check_eq("cu_no_host_grant", int'(host_grant), 0);
        tick();
        check_eq("cu_op_done", int'(op_done), 1);
        check_eq("cu_grant_one_cycle", int'(cu_grant), 0);
        tick();
        check_eq("cu_back_idle", int'({op_done, cu_grant, host_grant}), 0);
    endtask

    // mode 0: handshake low for the first stall_len cycles, then high; mode 1: 0/1 toggle.
    task automatic host_op(input int kind, input int mode, input int stall_len,
                           input logic done_val);
        int   cyc;
        int   exp_cnt;
        int   exp_cyc;
        logic hs;
        cyc     = 0;
        exp_cnt = 0;
        exp_q.push_back('{kind, int'(BYTES)});
        if (kind == 1) host_load_req = 1'b1;
        else host_rd_req = 1'b1;
        tick();
        host_load_req = 1'b0;
        host_rd_req   = 1'b0;
        check_eq("host_grant_latency", int'(host_grant), 1);
        if (kind == 1) check_eq("perr_clear_on_load", int'(proto_err), 0);
        while (!op_done && cyc < 1000) begin
            hs = (mode == 1) ? ((cyc % 2) == 1) : (cyc >= stall_len);
            if (kind == 1) host_in_valid = hs;
            else host_out_ready = hs;
            #1;
            check_eq("byte_cnt", int'(byte_cnt), exp_cnt);
            check_eq("strobe_follows_hs", int'(kind == 1 ? mcu_line_read_from_host_en
                                                         : mcu_line_write_to_host_en), int'(hs));
            if (hs) exp_cnt = (exp_cnt + 1) % int'(BYTES);
            cyc++;
            tick();
        end
        host_in_valid  = 1'b0;
        host_out_ready = 1'b0;
        exp_cyc = (mode == 1) ? 2 * int'(BYTES) : int'(BYTES) + stall_len;
        check_eq("op_done_reached", int'(op_done), 1);
        check_eq("granted_cycles", cyc, exp_cyc);
        check_eq("cnt_wrapped", int'(byte_cnt), 0);
        mcu_done_flag = done_val;
        tick();
        mcu_done_flag = 1'b0;
        check_eq("idle_after_finish", int'({op_done, host_grant}), 0);
    endtask

    initial begin
        int n;
        int cyc;

        #1;
        check_eq("outs_in_reset", all_outs(), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("outs_after_reset", all_outs(), 0);

        cu_op();

        host_op(1, 0, 0, 1'b1);
        check_eq("perr_good_load", int'(proto_err), 0);
        host_op(1, 1, 0, 1'b1);
        check_eq("perr_toggled_load", int'(proto_err), 0);
        host_op(1, 0, 0, 1'b0);
        check_eq("perr_set_missing_done", int'(proto_err), 1);
        cu_op();
        check_eq("perr_sticky_cu", int'(proto_err), 1);
        host_op(2, 0, 10, 1'b0);
        check_eq("perr_sticky_read", int'(proto_err), 1);
        host_op(1, 0, 0, 1'b1);
        check_eq("perr_cleared_by_load", int'(proto_err), 0);

        // Tie between host load and cu: host first after reset, then alternate.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.push_back('{1, int'(BYTES)});
        exp_q.push_back('{0, 1});
        exp_q.push_back('{1, int'(BYTES)});
        exp_q.push_back('{0, 1});
        cu_wr_req     = 1'b1;
        host_load_req = 1'b1;
        host_in_valid = 1'b1;
        mcu_done_flag = 1'b1;
        n   = 0;
        cyc = 0;
        while (n < 4 && cyc < 2000) begin
            tick();
            cyc++;
            if (op_done) n++;
        end
        cu_wr_req     = 1'b0;
        host_load_req = 1'b0;
        check_eq("arb_ops_done", n, 4);
        tick();
        tick();

        // Load and read together: load must win.
        exp_q.push_back('{1, int'(BYTES)});
        host_load_req  = 1'b1;
        host_rd_req    = 1'b1;
        host_out_ready = 1'b1;
        cyc = 0;
        while (!op_done && cyc < 1000) begin
            tick();
            cyc++;
        end
        host_load_req  = 1'b0;
        host_rd_req    = 1'b0;
        check_eq("load_over_read_done", int'(op_done), 1);
        tick();
        host_in_valid  = 1'b0;
        host_out_ready = 1'b0;
        mcu_done_flag  = 1'b0;
        tick();

        // Reset in the middle of a line.
        exp_q.push_back('{1, int'(BYTES)});
        host_load_req = 1'b1;
        tick();
        host_load_req = 1'b0;
        host_in_valid = 1'b1;
        repeat (20) tick();
        check_eq("cnt_before_reset", int'(byte_cnt), 20);
        rst_n = 1'b0;
        #1;
        check_eq("outs_async_reset", all_outs(), 0);
        void'(exp_q.pop_back());
        host_in_valid = 1'b0;
        tick();
        tick();
        check_eq("no_op_done_in_reset", int'(op_done), 0);
        rst_n = 1'b1;
        tick();
        check_eq("outs_after_midline_reset", all_outs(), 0);
        host_op(1, 0, 0, 1'b1);
        check_eq("perr_after_restart", int'(proto_err), 0);

        tick();
        tick();
        check_eq("scoreboard_drained", int'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=%0d exp=%0d", total, 0);
        $fatal(1, "watchdog");
    end

endmodule
